// File: rtl/partial_product_stage.sv
// Registered partial-product generator feeding the adder tree: one shifted copy of
// the multiplicand per multiplier bit, behind a two-entry skid buffer.

module pp_lane #(
  parameter int A_WIDTH    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX        = 0
) (
  input  logic [A_WIDTH-1:0]    a,
  input  logic                  b_bit,
  output logic [DATA_WIDTH-1:0] pp
);
  // Truncating before the shift leaves the low DATA_WIDTH bits unchanged.
  assign pp = b_bit ? (DATA_WIDTH'(a) << IDX) : '0;
endmodule

module partial_product_stage #(
  parameter int SIZE       = 5,
  parameter int A_WIDTH    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         in_a,
  input  logic [SIZE-1:0]            in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE*DATA_WIDTH-1:0] out_pp
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                             state;
  logic [SIZE-1:0][DATA_WIDTH-1:0]    pp_in, main_q, skid_q;
  logic                               accept, emit;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    pp_lane #(.A_WIDTH(A_WIDTH), .DATA_WIDTH(DATA_WIDTH), .IDX(i)) u_lane (
      .a     (in_a),
      .b_bit (in_b[i]),
      .pp    (pp_in[i])
    );
  end

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;
  assign out_pp = main_q;

  // in_ready/out_valid are registered alongside the state they are derived from.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_q    <= pp_in;
          state     <= ONE;
          out_valid <= 1'b1;
        end
        ONE: begin
          case ({accept, emit})
            2'b10: begin
              skid_q   <= pp_in;
              state    <= TWO;
              in_ready <= 1'b0;
            end
            2'b01: begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
            2'b11:   main_q <= pp_in;
            default: ;
          endcase
        end
        TWO: if (emit) begin
          main_q   <= skid_q;
          state    <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_partial_product_stage.sv
// Randomized and directed checks of partial_product_stage against an occupancy/queue model.

module tb_partial_product_stage;
  localparam int SIZE = 5;
  localparam int AW   = 4;
  localparam int DW   = 8;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, out_valid, out_ready;
  logic [AW-1:0]        in_a;
  logic [SIZE-1:0]      in_b;
  logic [SIZE*DW-1:0]   out_pp;

  int compared = 0;
  int mismatched = 0;
  int n_out = 0;
  logic [AW+SIZE-1:0] q[$];
  bit                 prev_hold = 1'b0;
  logic [SIZE*DW-1:0] prev_pp = '0;

  partial_product_stage #(.SIZE(SIZE), .A_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pp    (out_pp)
  );

  always #5 clk = ~clk;

  // Reference: lane i is a*2^i when multiplier bit i is set, kept modulo 2^DW.
  function automatic logic [SIZE*DW-1:0] exp_pp(input logic [AW+SIZE-1:0] pair);
    int a, b;
    logic [SIZE*DW-1:0] r;
    a = int'(pair[AW+SIZE-1:SIZE]);
    b = int'(pair[SIZE-1:0]);
    r = '0;
    for (int i = 0; i < SIZE; i++)
      if (((b >> i) & 1) == 1) r[i*DW +: DW] = DW'((a * (1 << i)) % (1 << DW));
    return r;
  endfunction

  function automatic logic [DW-1:0] tree_sum(input logic [SIZE*DW-1:0] v);
    int s = 0;
    for (int i = 0; i < SIZE; i++) s += int'(v[i*DW +: DW]);
    return DW'(s % (1 << DW));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check against the model, clock, return accept.
  task automatic step(input bit iv, input bit ordy, input logic [AW-1:0] a,
                      input logic [SIZE-1:0] b, input bit r, output bit acc);
    logic [AW+SIZE-1:0] head;
    in_valid = iv; out_ready = ordy; in_a = a; in_b = b; rst = r;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (prev_hold) chk("hold", 64'(out_pp), 64'(prev_pp));
    acc = iv && in_ready && !r;
    if (out_valid && ordy && !r && q.size() != 0) begin
      head = q.pop_front();
      chk("pp", 64'(out_pp), 64'(exp_pp(head)));
      chk("sum", 64'(tree_sum(out_pp)),
          64'((int'(head[AW+SIZE-1:SIZE]) * int'(head[SIZE-1:0])) % 256));
      n_out++;
    end
    if (acc) q.push_back({a, b});
    prev_hold = out_valid && !ordy && !r;
    prev_pp   = out_pp;
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      q.delete();
      prev_hold = 1'b0;
    end
  endtask

  initial begin
    bit acc;
    int sent, base;
    logic [AW-1:0] ra;
    logic [SIZE-1:0] rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_pp", 64'(out_pp), 64'd0);

    // Single product, then the wrapping case.
    step(1, 1, 4'hB, 5'b10110, 0, acc);
    chk("single_pp", 64'(out_pp), 64'hB0_00_2C_16_00);
    chk("single_sum", 64'(tree_sum(out_pp)), 64'hF2);
    step(1, 1, 4'hF, 5'h1F, 0, acc);
    chk("wrap_pp", 64'(out_pp), 64'hF0_78_3C_1E_0F);
    chk("wrap_sum", 64'(tree_sum(out_pp)), 64'hD1);
    step(0, 1, '0, '0, 0, acc);

    // Backpressure: P1, P2 accepted, P3 held until the stall clears.
    step(1, 0, 4'h3, 5'h05, 0, acc);
    chk("bp_acc1", 64'(acc), 64'd1);
    step(1, 0, 4'h7, 5'h0A, 0, acc);
    chk("bp_acc2", 64'(acc), 64'd1);
    chk("bp_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'h9, 5'h13, 0, acc);
      chk("bp_p3_held", 64'(acc), 64'd0);
      chk("bp_main_p1", 64'(out_pp), 64'(exp_pp({4'h3, 5'h05})));
    end
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(1, 1, 4'h9, 5'h13, 0, acc);
    chk("bp_p3_taken", 64'(acc), 64'd1);
    for (int i = 0; i < 10 && q.size() != 0; i++) step(0, 1, '0, '0, 0, acc);
    chk("bp_drain", 64'(q.size()), 64'd0);

    // Streaming at full rate.
    for (int i = 0; i < 20; i++) begin
      ra = AW'($urandom); rb = SIZE'($urandom);
      step(1, 1, ra, rb, 0, acc);
      chk("stream_acc", 64'(acc), 64'd1);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) step(0, 1, '0, '0, 0, acc);
    chk("stream_drain", 64'(q.size()), 64'd0);

    // Random stalls against 100 pairs; a pair is held until accepted.
    sent = 0; base = n_out;
    ra = AW'($urandom); rb = SIZE'($urandom);
    for (int c = 0; c < 3000 && sent < 100; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, rb, 0, acc);
      if (acc) begin
        sent++;
        ra = AW'($urandom); rb = SIZE'($urandom);
      end
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 1, '0, '0, 0, acc);
    chk("rand_sent", 64'(sent), 64'd100);
    chk("rand_count", 64'(n_out - base), 64'd100);

    // Reset while holding two entries.
    step(1, 0, 4'h5, 5'h11, 0, acc);
    step(1, 0, 4'h6, 5'h0F, 0, acc);
    chk("pre_rst_ready", 64'(in_ready), 64'd0);
    step(1, 1, 4'hC, 5'h1C, 1, acc);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_pp", 64'(out_pp), 64'd0);
    step(1, 1, 4'hD, 5'h19, 0, acc);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_pp", 64'(out_pp), 64'(exp_pp({4'hD, 5'h19})));
    step(0, 1, '0, '0, 0, acc);
    step(0, 1, '0, '0, 0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
